// File: rtl/uart_send_pkg.sv
// Shared types and defaults for the uart_send transmitter.
// Optional parity frame format is enabled with UART_SEND_PARITY_EN.
package uart_send_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_send_tx_sync_2ff.sv
// Two-flop synchronizer for a single-bit level or toggle signal.
// Async active-low reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_send_tx.sv
// Toggle-handshake 8N1 UART serializer on a 16x baud clock.
// Define UART_SEND_PARITY_EN to add an even-parity bit before stop.
module uart_send_tx
  import uart_send_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk_uart16,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 local_st,
  output logic                 remote_st,
  output logic                 tx
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_tx_state_t       state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 local_sync;
  logic                 tick_end;
`ifdef UART_SEND_PARITY_EN
  logic                 par;
`endif

  sync_2ff u_sync (
    .clk   (clk_uart16),
    .rst_n (rst_n),
    .d     (local_st),
    .q     (local_sync)
  );

  assign tick_end = (tick == TICK_LAST);

  // tx is loaded with the value for the next state so it stays registered
  always_ff @(posedge clk_uart16 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      remote_st <= 1'b0;
`ifdef UART_SEND_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (local_sync != remote_st) begin
            shreg   <= data;
            tick    <= '0;
            bit_cnt <= '0;
            tx      <= 1'b0;
            state   <= START;
`ifdef UART_SEND_PARITY_EN
            par     <= ^data;
`endif
          end
        end
        START: begin
          if (tick_end) begin
            tick  <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        DATA: begin
          if (tick_end) begin
            tick <= '0;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_SEND_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
`ifdef UART_SEND_PARITY_EN
        PARITY: begin
          if (tick_end) begin
            tick  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tick <= tick + TW'(1);
          end
        end
`endif
        STOP: begin
          if (tick_end) begin
            tick      <= '0;
            remote_st <= ~remote_st;
            state     <= IDLE;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send_tx.sv
// Directed self-checking bench for uart_send_tx.
// Frame expectations follow UART_SEND_PARITY_EN when it is defined.
module tb_uart_send_tx;

`ifdef UART_SEND_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int LAST = 2 + NSLOT * 16;
  localparam int NCAP = LAST + 8;

  logic       clk_uart16;
  logic       rst_n;
  logic [7:0] data;
  logic       local_st;
  logic       remote_st;
  logic       tx;

  int tests;
  int fails;

  logic txs [0:NCAP-1];
  logic rem [0:NCAP-1];

  uart_send_tx dut (
    .clk_uart16 (clk_uart16),
    .rst_n      (rst_n),
    .data       (data),
    .local_st   (local_st),
    .remote_st  (remote_st),
    .tx         (tx)
  );

  initial clk_uart16 = 1'b0;
  always #5 clk_uart16 = ~clk_uart16;

  // expected tx after clock edge k, edge 0 being the first after the request
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    int j;
    if (k < 2) return 1'b1;
    j = (k - 2) / 16;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_SEND_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic capture();
    for (int k = 0; k < NCAP; k++) begin
      @(negedge clk_uart16);
      txs[k] = tx;
      rem[k] = remote_st;
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] b);
    int errs;
    int first;
    errs = 0;
    first = -1;
    for (int k = 0; k < NCAP; k++) begin
      if (txs[k] !== exp_tx(k, b)) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL %s: %0d bad cycles, first at %0d got %b want %b",
               name, errs, first, txs[first], exp_tx(first, b));
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    local_st = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk_uart16);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL reset_tx: got %b want 1", tx);
    end
    tests++;
    if (remote_st !== 1'b0) begin
      fails++;
      $display("FAIL reset_remote: got %b want 0", remote_st);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_uart16);
      if (tx !== 1'b1 || remote_st !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_idle: %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_single();
    data = 8'hA5;
    local_st = 1'b1;
    capture();
    check_frame("single_a5", 8'hA5);
    tests++;
    if (txs[1] !== 1'b1 || txs[2] !== 1'b0) begin
      fails++;
      $display("FAIL start_edge: got %b%b want 10", txs[1], txs[2]);
    end
    tests++;
    if (txs[17] !== 1'b0 || txs[18] !== 1'b1) begin
      fails++;
      $display("FAIL start_width: got %b%b want 01", txs[17], txs[18]);
    end
    tests++;
    if (rem[LAST-1] !== 1'b0 || rem[LAST] !== 1'b1) begin
      fails++;
      $display("FAIL single_done: got %b%b want 01", rem[LAST-1], rem[LAST]);
    end
  endtask

  task automatic test_back_to_back();
    data = 8'h00;
    local_st = 1'b0;
    capture();
    check_frame("b2b_00", 8'h00);
    tests++;
    if (rem[LAST-1] !== 1'b1 || rem[LAST] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done: got %b%b want 10", rem[LAST-1], rem[LAST]);
    end
  endtask

  task automatic test_data_change();
    data = 8'hFF;
    local_st = 1'b1;
    fork
      capture();
      begin
        repeat (10) @(negedge clk_uart16);
        data = 8'h00;
      end
    join
    check_frame("data_change", 8'hFF);
    tests++;
    if (rem[LAST] !== 1'b1) begin
      fails++;
      $display("FAIL change_done: got %b want 1", rem[LAST]);
    end
  endtask

  task automatic test_reset_mid();
    data = 8'h81;
    local_st = 1'b0;
    capture();
    check_frame("pre_81", 8'h81);
    data = 8'h3C;
    local_st = 1'b1;
    repeat (2 + 16 * 4 + 8) @(negedge clk_uart16);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL bit3_pre: got %b want 1", tx);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || remote_st !== 1'b0) begin
      fails++;
      $display("FAIL async_abort: tx %b rem %b want 1 0", tx, remote_st);
    end
    repeat (3) @(negedge clk_uart16);
    rst_n = 1'b1;
    capture();
    check_frame("restart_3c", 8'h3C);
    tests++;
    if (rem[LAST-1] !== 1'b0 || rem[LAST] !== 1'b1) begin
      fails++;
      $display("FAIL restart_done: got %b%b want 01", rem[LAST-1], rem[LAST]);
    end
  endtask

`ifdef UART_SEND_PARITY_EN
  task automatic test_parity();
    data = 8'h07;
    local_st = 1'b0;
    capture();
    check_frame("parity_07", 8'h07);
    tests++;
    if (txs[2 + 16 * 9 + 8] !== 1'b1) begin
      fails++;
      $display("FAIL parity_bit: got %b want 1", txs[2 + 16 * 9 + 8]);
    end
    tests++;
    if (rem[177] !== 1'b1 || rem[178] !== 1'b0) begin
      fails++;
      $display("FAIL parity_len: got %b%b want 10", rem[177], rem[178]);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_data_change();
    test_reset_mid();
`ifdef UART_SEND_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
